// File: rtl/ram_sp_init.sv
// Single-port RAM that fills itself with INIT_VAL after reset or on request,
// then serves one registered read or write per cycle; rejected accesses are counted.
//
// state | meaning
// CLEAR | sweeping INIT_VAL through every word, one per cycle; array owned internally
// IDLE  | array open to external read/write accesses
module ram_sp_init #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 10,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              clr_req,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              clr_done,
   output logic [7:0]        drop_cnt
);

   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;
   logic              rd_en;
   logic              drop;
   logic              done_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      mem_we       = 1'b0;
      mem_wa       = addr;
      mem_wd       = data_in;
      rd_en        = 1'b0;
      drop         = 1'b0;
      done_nxt     = 1'b0;
      case (state)
         CLEAR: begin
            mem_we       = 1'b1;
            mem_wa       = clr_addr;
            mem_wd       = INIT_VAL;
            clr_addr_nxt = clr_addr + 1'b1;
            drop         = sel;
            if (clr_addr == LAST_ADDR) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         IDLE: begin
            if (clr_req) begin
               state_nxt    = CLEAR;
               clr_addr_nxt = '0;
               drop         = sel;
            end else if (sel) begin
               if (write) begin
                  mem_we = 1'b1;
               end else begin
                  rd_en = 1'b1;
               end
            end
         end
         default: begin
            state_nxt    = CLEAR;
            clr_addr_nxt = '0;
         end
      endcase
      // reset must never disturb array contents or produce read data
      if (rst) begin
         mem_we = 1'b0;
         rd_en  = 1'b0;
      end
   end

   // array kept free of reset so it maps onto a plain RAM
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         rd_valid <= 1'b0;
         clr_done <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         rd_valid <= rd_en;
         clr_done <= done_nxt;
         if (rd_en) begin
            data_out <= mem[addr];
         end
         if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   assign busy = (state == CLEAR);

endmodule

// File: tb/tb_ram_sp_init.sv
// Randomised bench for ram_sp_init: a cycle model built on a "clear words remaining"
// count and a plain array is compared every cycle, plus literal directed expectations.
module tb_ram_sp_init;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel;
   logic       write;
   logic [9:0] addr;
   logic [7:0] data_in;
   logic       clr_req;
   logic [7:0] data_out;
   logic       rd_valid;
   logic       busy;
   logic       clr_done;
   logic [7:0] drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   ram_sp_init dut (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel),
      .write    (write),
      .addr     (addr),
      .data_in  (data_in),
      .clr_req  (clr_req),
      .data_out (data_out),
      .rd_valid (rd_valid),
      .busy     (busy),
      .clr_done (clr_done),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   // behavioural model: state is just "how many clear writes are still owed"
   logic [7:0] m_mem [1024];
   int         clr_left;
   logic [7:0] exp_dout;
   logic       exp_rv;
   logic       exp_done;
   int         exp_drop;
   bit         model_on = 0;

   always @(posedge clk) begin
      if (rst) begin
         clr_left = 1024;
         exp_dout = 8'd0;
         exp_rv   = 1'b0;
         exp_done = 1'b0;
         exp_drop = 0;
         model_on = 1;
      end else if (model_on) begin
         exp_rv   = 1'b0;
         exp_done = 1'b0;
         if (clr_left > 0) begin
            m_mem[1024 - clr_left] = 8'd0;
            clr_left = clr_left - 1;
            if (clr_left == 0) exp_done = 1'b1;
            if (sel && exp_drop < 255) exp_drop = exp_drop + 1;
         end else if (clr_req) begin
            clr_left = 1024;
            if (sel && exp_drop < 255) exp_drop = exp_drop + 1;
         end else if (sel) begin
            if (write) m_mem[addr] = data_in;
            else begin
               exp_dout = m_mem[addr];
               exp_rv   = 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_on) begin
         check("busy",     {31'd0, busy},     {31'd0, clr_left > 0});
         check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rv});
         check("data_out", {24'd0, data_out}, {24'd0, exp_dout});
         check("clr_done", {31'd0, clr_done}, {31'd0, exp_done});
         check("drop_cnt", {24'd0, drop_cnt}, exp_drop);
      end
   end

   task automatic drive(input logic s, input logic w, input logic [9:0] a,
                        input logic [7:0] d, input logic c);
      sel     = s;
      write   = w;
      addr    = a;
      data_in = d;
      clr_req = c;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
   endtask

   // counts negedges with busy high, leaving the bench on the first idle negedge
   task automatic busy_count(output int n);
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         n++;
         idle();
      end
   endtask

   int         n;
   logic [9:0] ra;

   initial begin
      rst = 1'b1;
      sel = 1'b0; write = 1'b0; addr = '0; data_in = '0; clr_req = 1'b0;
      @(negedge clk);
      check("reset_busy",     {31'd0, busy},     32'd1);
      check("reset_drop",     {24'd0, drop_cnt}, 32'd0);
      check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("reset_data_out", {24'd0, data_out}, 32'd0);
      rst = 1'b0;

      busy_count(n);
      check("init_busy_cycles", n, 32'd1024);
      check("init_clr_done",    {31'd0, clr_done}, 32'd1);
      foreach (ra_list[i]) begin
         drive(1'b1, 1'b0, ra_list[i], 8'h00, 1'b0);
         check("init_read_valid", {31'd0, rd_valid}, 32'd1);
         check("init_read_data",  {24'd0, data_out}, 32'd0);
      end

      for (int k = 0; k < 1024; k++) begin
         drive(1'b1, 1'b1, 10'(k), 8'((k + k) % 256), 1'b0);
         check("write_no_valid", {31'd0, rd_valid}, 32'd0);
      end
      for (int i = 0; i < 20; i++) begin
         ra = 10'($urandom_range(0, 1023));
         drive(1'b1, 1'b0, ra, 8'h00, 1'b0);
         check("pattern_read_valid", {31'd0, rd_valid}, 32'd1);
         check("pattern_read_data",  {24'd0, data_out}, (2 * int'(ra)) % 256);
      end

      // random mixed traffic, occasional clear request
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               10'($urandom_range(0, 31)), 8'($urandom), ($urandom_range(0, 79) == 0));
      end
      busy_count(n);

      drive(1'b1, 1'b1, 10'd7, 8'hA5, 1'b0);
      drive(1'b1, 1'b0, 10'd7, 8'h00, 1'b0);
      check("raw_read_data", {24'd0, data_out}, 32'hA5);
      drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b1);
      busy_count(n);
      check("req_busy_cycles", n, 32'd1024);
      check("req_clr_done",    {31'd0, clr_done}, 32'd1);
      drive(1'b1, 1'b0, 10'd7, 8'h00, 1'b0);
      check("cleared_read_valid", {31'd0, rd_valid}, 32'd1);
      check("cleared_read_data",  {24'd0, data_out}, 32'h00);

      drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b1);
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), 10'($urandom), 8'($urandom), 1'b0);
         check("busy_no_valid", {31'd0, rd_valid}, 32'd0);
      end
      check("drop_saturated", {24'd0, drop_cnt}, 32'd255);
      rst = 1'b1;
      idle();
      check("drop_after_rst", {24'd0, drop_cnt}, 32'd0);
      rst = 1'b0;
      busy_count(n);
      check("rst_mid_clear_busy", n, 32'd1024);

      drive(1'b1, 1'b0, 10'd3, 8'h00, 1'b1);
      check("collide_no_valid", {31'd0, rd_valid}, 32'd0);
      check("collide_drop",     {24'd0, drop_cnt}, 32'd1);
      check("collide_busy",     {31'd0, busy},     32'd1);
      busy_count(n);
      check("collide_busy_cycles", n, 32'd1024);

      rst = 1'b1;
      idle();
      rst = 1'b0;
      for (int i = 0; i < 500; i++) idle();
      rst = 1'b1;
      idle();
      rst = 1'b0;
      busy_count(n);
      check("abort_busy_cycles", n, 32'd1024);
      check("abort_clr_done",    {31'd0, clr_done}, 32'd1);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   logic [9:0] ra_list [3] = '{10'd0, 10'd511, 10'd1023};

endmodule
